seq_shift_unit: RTL and testbench

//  Parametrised multi-cycle shifter for the processor datapath. Generalises the fixed x256 left shift
//  to run-time amount and direction, with logical, arithmetic and rotate modes.

---
 rtl/seq_shift_unit.sv | 166 ++++++++++++++++
 tb/tb_seq_shift_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter (SLL / SRL / SRA / ROL) with a
// start/busy/done handshake, moving up to STEP bits per clock.
// Optional build macro SHIFT_CARRY_EN adds the carry_out port, which reports
// the last bit shifted out of the operand.
module seq_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
`ifdef SHIFT_CARRY_EN
  ,
  output logic               carry_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SHIFT_CARRY_EN
  logic               cwork_q, cwork_d;
  logic               carry_q, carry_d;
`endif

  // One-bit step of the selected shift; SRA keeps the MSB, which is the
  // original sign bit because SRA never changes it.
  function automatic logic [WIDTH-1:0] shift_word(input op_e op_v, input logic [WIDTH-1:0] w);
    case (op_v)
      OP_SLL:  return {w[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, w[WIDTH-1:1]};
      OP_SRA:  return {w[WIDTH-1], w[WIDTH-1:1]};
      default: return {w[WIDTH-2:0], w[WIDTH-1]};
    endcase
  endfunction

`ifdef SHIFT_CARRY_EN
  // The bit that leaves the word on a one-bit step.
  function automatic logic shift_bit_out(input op_e op_v, input logic [WIDTH-1:0] w);
    case (op_v)
      OP_SRL, OP_SRA: return w[0];
      default:        return w[WIDTH-1];
    endcase
  endfunction
`endif

  int  k;
  logic last;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
`ifdef SHIFT_CARRY_EN
    cwork_d = cwork_q;
    carry_d = carry_q;
`endif
    k    = (int'(cnt_q) < STEP) ? int'(cnt_q) : STEP;
    last = (int'(cnt_q) <= STEP);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = in;
          cnt_d   = shamt;
          op_d    = op_e'(op);
          state_d = S_SHIFT;
`ifdef SHIFT_CARRY_EN
          cwork_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        for (int i = 0; i < STEP; i++) begin
          if (i < k) begin
`ifdef SHIFT_CARRY_EN
            cwork_d = shift_bit_out(op_q, work_d);
`endif
            work_d = shift_word(op_q, work_d);
          end
        end
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          out_d   = work_d;
`ifdef SHIFT_CARRY_EN
          carry_d = cwork_d;
`endif
        end else begin
          cnt_d = cnt_q - SHAMT_W'(STEP);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      cwork_q <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_CARRY_EN
      cwork_q <= cwork_d;
      carry_q <= carry_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
`ifdef SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: three instances (STEP = 1, 4, 16) checked against
// an arithmetic reference model, with directed cases and random operations.
module tb_seq_shift_unit;

  localparam int W = 16;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_a [N];
  logic        start_a [N];
  logic [1:0]  op_a    [N];
  logic [4:0]  shamt_a [N];
  logic [15:0] in_a    [N];
  logic        busy_a  [N];
  logic        done_a  [N];
  logic [15:0] out_a   [N];
`ifdef SHIFT_CARRY_EN
  logic        carry_a [N];
`endif

  logic [15:0] last_out   [N];
  logic        last_carry [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_shift_unit #(
      .WIDTH(16), .SHAMT_W(5), .STEP(g == 0 ? 1 : (g == 1 ? 4 : 16))
    ) dut (
      .clk(clk), .reset(reset_a[g]), .start(start_a[g]), .op(op_a[g]),
      .shamt(shamt_a[g]), .in(in_a[g]), .busy(busy_a[g]), .done(done_a[g]),
      .out(out_a[g])
`ifdef SHIFT_CARRY_EN
      , .carry_out(carry_a[g])
`endif
    );
  end

  function automatic int step_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 4 : 16);
  endfunction

  typedef struct packed { logic c; logic [15:0] v; } res_t;

  // Reference results from whole-word arithmetic.
  function automatic res_t model(input logic [1:0] op, input int sh, input logic [15:0] x_in);
    res_t r;
    logic [31:0] x, t;
    logic signed [15:0] si;
    int rr, s;
    x = {16'h0, x_in};
    r.c = 1'b0;
    case (op)
      2'b00: begin
        t = x << sh;
        r.v = t[15:0];
        if (sh != 0) r.c = t[16];
      end
      2'b01: begin
        t = x >> sh;
        r.v = t[15:0];
        if (sh != 0 && sh <= 16) r.c = x_in[sh-1];
      end
      2'b10: begin
        si = x_in;
        s = (sh > 15) ? 15 : sh;
        r.v = si >>> s;
        if (sh != 0) r.c = x_in[((sh > 16) ? 16 : sh) - 1];
      end
      default: begin
        rr = sh % 16;
        t = (x << rr) | (x >> (16 - rr));
        r.v = t[15:0];
        if (sh != 0) r.c = r.v[0];
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One full operation on instance idx with start hammered while busy.
  task automatic run_op(input int idx, input logic [1:0] op, input int sh, input logic [15:0] x);
    res_t r;
    int lat, cycles, dones, done_at;
    logic hold_ok;
    r = model(op, sh, x);
    lat = (sh == 0) ? 1 : (sh + step_of(idx) - 1) / step_of(idx);
    @(negedge clk);
    op_a[idx] = op; shamt_a[idx] = 5'(sh); in_a[idx] = x; start_a[idx] = 1'b1;
    @(negedge clk);
    cycles = 0; dones = 0; done_at = -1; hold_ok = 1'b1;
    while (busy_a[idx] === 1'b1 && cycles < 100) begin
      cycles++;
      if (done_a[idx] === 1'b1) begin
        dones++;
        done_at = cycles;
      end else if (out_a[idx] !== last_out[idx]) begin
        hold_ok = 1'b0;
      end
      start_a[idx] = 1'($urandom);
      op_a[idx]    = 2'($urandom);
      shamt_a[idx] = 5'($urandom);
      in_a[idx]    = 16'($urandom);
      @(negedge clk);
    end
    start_a[idx] = 1'b0;
    check($sformatf("busy_cycles i%0d op%0d sh%0d", idx, op, sh), cycles, lat + 1);
    check($sformatf("done_count i%0d", idx), dones, 1);
    check($sformatf("done_pos i%0d", idx), done_at, lat + 1);
    check($sformatf("out_hold i%0d", idx), {31'b0, hold_ok}, 1);
    check($sformatf("out i%0d op%0d sh%0d in%0h", idx, op, sh, x), {16'b0, out_a[idx]}, {16'b0, r.v});
`ifdef SHIFT_CARRY_EN
    check($sformatf("carry i%0d op%0d sh%0d in%0h", idx, op, sh, x), {31'b0, carry_a[idx]}, {31'b0, r.c});
`endif
    check($sformatf("done_low i%0d", idx), {31'b0, done_a[idx]}, 0);
    last_out[idx]   = r.v;
    last_carry[idx] = r.c;
  endtask

  initial begin
    int dones;
    for (int i = 0; i < N; i++) begin
      reset_a[i] = 1'b1; start_a[i] = 1'b1; op_a[i] = 2'b00;
      shamt_a[i] = 5'd3; in_a[i] = 16'hFFFF;
      last_out[i] = 16'h0; last_carry[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_busy i%0d", i), {31'b0, busy_a[i]}, 0);
      check($sformatf("rst_done i%0d", i), {31'b0, done_a[i]}, 0);
      check($sformatf("rst_out i%0d", i), {16'b0, out_a[i]}, 0);
`ifdef SHIFT_CARRY_EN
      check($sformatf("rst_carry i%0d", i), {31'b0, carry_a[i]}, 0);
`endif
      reset_a[i] = 1'b0; start_a[i] = 1'b0;
    end

    // Directed cases.
    run_op(0, 2'b00, 8, 16'h00AB);
    check("t1_const", {16'b0, out_a[0]}, 32'hAB00);
    run_op(1, 2'b10, 6, 16'h8F00);
    check("t2_const", {16'b0, out_a[1]}, 32'hFE3C);
    run_op(0, 2'b11, 1, 16'h8001);
    check("t3_rol_const", {16'b0, out_a[0]}, 32'h0003);
    run_op(0, 2'b01, 0, 16'h8001);
    check("t3_srl0_const", {16'b0, out_a[0]}, 32'h8001);
    run_op(2, 2'b00, 20, 16'hFFFF);
    check("t4_sll_const", {16'b0, out_a[2]}, 32'h0000);
    run_op(2, 2'b10, 20, 16'h8000);
    check("t4_sra_const", {16'b0, out_a[2]}, 32'hFFFF);
    run_op(2, 2'b11, 20, 16'h0001);
    check("t4_rol_const", {16'b0, out_a[2]}, 32'h0010);
    run_op(0, 2'b00, 31, 16'hFFFF);
    run_op(1, 2'b10, 31, 16'h4000);

    // Reset during the third SHIFT cycle of an 8-bit shift.
    run_op(0, 2'b11, 4, 16'h1234);
    @(negedge clk);
    op_a[0] = 2'b00; shamt_a[0] = 5'd8; in_a[0] = 16'h00FF; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_a[0] = 1'b1;
    @(negedge clk);
    reset_a[0] = 1'b0;
    check("abort_busy", {31'b0, busy_a[0]}, 0);
    check("abort_done", {31'b0, done_a[0]}, 0);
    check("abort_out", {16'b0, out_a[0]}, 0);
`ifdef SHIFT_CARRY_EN
    check("abort_carry", {31'b0, carry_a[0]}, 0);
`endif
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a[0] === 1'b1 || busy_a[0] === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    last_out[0] = 16'h0; last_carry[0] = 1'b0;

    // Reset and start on the same edge: start is dropped.
    start_a[0] = 1'b1; reset_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0; reset_a[0] = 1'b0;
    check("rst_start_busy", {31'b0, busy_a[0]}, 0);
    run_op(0, 2'b00, 3, 16'h0F0F);

    // Random operations across all three step sizes.
    for (int n = 0; n < 36; n++) begin
      run_op(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 31)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
